// File: rtl/uart_tx_engine.sv
// UART transmitter: one start bit, DATA_BITS payload (LSB first), STOP_BITS stop bits per accepted byte.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the payload.
module uart_tx_engine #(
    parameter int unsigned CLK_FREQ  = 6_914_890,
    parameter int unsigned BAUDRATE  = 38400,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 ready_in,
    output logic                 done_in,
    output logic                 tx,
    output logic                 busy
);
    localparam int unsigned DIV   = (CLK_FREQ + BAUDRATE / 2) / BAUDRATE;
    localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_engine: DIV = CLK_FREQ/BAUDRATE must be at least 2");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       baud_q, baud_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   armed_q, armed_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   baud_end;
    logic                   can_take;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    assign baud_end = (baud_q == BAUD_LAST);
    assign tx       = tx_q;
    assign busy     = busy_q;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_end ? '0 : baud_q + CNT_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        armed_d  = armed_q | ~ready_in;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_in  = 1'b0;
        can_take = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                tx_d     = 1'b1;
                busy_d   = 1'b0;
                baud_d   = '0;
                bit_d    = '0;
                can_take = 1'b1;
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d  = S_IDLE;
                        tx_d     = 1'b1;
                        busy_d   = 1'b0;
                        bit_d    = '0;
                        can_take = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Capture overrides the case above; taking it on the last stop edge chains frames with no idle gap.
        if (can_take && ready_in && armed_q) begin
            state_d  = S_START;
            shift_d  = data_in;
            armed_d  = 1'b0;
            busy_d   = 1'b1;
            tx_d     = 1'b0;
            done_in  = 1'b1;
            baud_d   = '0;
            bit_d    = '0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^data_in;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            armed_q  <= 1'b1;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            armed_q  <= armed_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine at DIV=4: frame waveforms compared cycle by cycle against a bit-index model.
module tb_uart_tx_engine;
    localparam int unsigned DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PBIT = 1;
`else
    localparam int unsigned PBIT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       ready_in = 1'b0;
    logic       done_in, tx, busy;
    logic [7:0] data2 = '0;
    logic       ready2 = 1'b0;
    logic       done2, tx2, busy2;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned done_cnt = 0;

    uart_tx_engine #(.CLK_FREQ(40), .BAUDRATE(10), .DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .ready_in(ready_in),
        .done_in(done_in), .tx(tx), .busy(busy)
    );

    uart_tx_engine #(.CLK_FREQ(40), .BAUDRATE(10), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .data_in(data2), .ready_in(ready2),
        .done_in(done2), .tx(tx2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done_in === 1'b1) done_cnt++;

    // Line level of bit slot idx of a frame: start, payload LSB first, optional parity, then stop ones.
    function automatic logic model_bit(input logic [7:0] b, input int unsigned idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PBIT == 1 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic int unsigned frame_len(input int unsigned stops);
        return (1 + 8 + PBIT + stops) * DIV;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [7:0] b, input bit hold);
        data_in  = b;
        ready_in = 1'b1;
        #1;
        chk("done_pulse", done_in, 1);
        tick();
        if (!hold) ready_in = 1'b0;
        data_in = 8'($urandom);
        #1;
        chk("done_one_cycle", done_in, 0);
    endtask

    task automatic check_frame(input logic [7:0] b, input logic [7:0] nb, input bit chain);
        int unsigned n;
        n = frame_len(1);
        for (int unsigned i = 0; i < n; i++) begin
            chk("tx_bit", tx, model_bit(b, i / DIV));
            chk("busy_frame", busy, 1);
            chk("done_frame", done_in, (chain && i == n - 1));
            if (chain && i == 1) begin
                ready_in = 1'b1;
                data_in  = nb;
            end
            tick();
        end
        if (!chain) begin
            chk("tx_idle", tx, 1);
            chk("busy_idle", busy, 0);
            chk("done_idle", done_in, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        int unsigned base;

        // reset state
        repeat (3) tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_in, 0);
        rst = 1'b0;
        tick();

        // reset during payload bit 3 of 0x55
        capture(8'h55, 0);
        for (int unsigned i = 0; i < 17; i++) begin
            chk("pre_rst_tx", tx, model_bit(8'h55, i / DIV));
            tick();
        end
        rst = 1'b1;
        tick();
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        rst = 1'b0;
        for (int unsigned i = 0; i < 60; i++) begin
            chk("abort_quiet_tx", tx, 1);
            chk("abort_quiet_busy", busy, 0);
            tick();
        end

        // single byte
        base = done_cnt;
        capture(8'hA5, 0);
        check_frame(8'hA5, 8'h00, 0);
        chk("single_done_cnt", done_cnt - base, 1);

        // sticky producer
        base = done_cnt;
        capture(8'h3C, 1);
        check_frame(8'h3C, 8'h00, 0);
        repeat (159) tick();
        chk("sticky_done_cnt", done_cnt - base, 1);
        chk("sticky_tx", tx, 1);
        chk("sticky_busy", busy, 0);
        ready_in = 1'b0;
        tick();
        capture(8'h3C, 0);
        check_frame(8'h3C, 8'h00, 0);
        chk("sticky_rearm_cnt", done_cnt - base, 2);

        // back-to-back, no idle gap between frames
        capture(8'h00, 0);
        check_frame(8'h00, 8'hFF, 1);
        ready_in = 1'b0;
        #1;
        chk("b2b_done_drop", done_in, 0);
        check_frame(8'hFF, 8'h00, 0);

        // random payloads
        repeat (6) begin
            b = 8'($urandom);
            capture(b, 0);
            check_frame(b, 8'h00, 0);
        end

`ifdef UART_TX_PARITY_EN
        capture(8'h07, 0);
        check_frame(8'h07, 8'h00, 0);
        capture(8'h03, 0);
        check_frame(8'h03, 8'h00, 0);
`endif

        // two stop bits
        data2  = 8'h80;
        ready2 = 1'b1;
        #1;
        chk("stop2_done", done2, 1);
        tick();
        ready2 = 1'b0;
        data2  = 8'($urandom);
        for (int unsigned i = 0; i < frame_len(2); i++) begin
            chk("stop2_tx", tx2, model_bit(8'h80, i / DIV));
            chk("stop2_busy", busy2, 1);
            tick();
        end
        chk("stop2_tx_end", tx2, 1);
        chk("stop2_busy_end", busy2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
